// File: rtl/conv_pkg.sv
// Shared definitions for the conv job front-end.
//   - DSIZE_DEF / KSIZE_DEF : default memory depth and maximum kernel size of the attached conv
//   - state_e               : sequencer FSM states
//   - calc_nwords           : number of 32-bit words that carry a W x H byte image
package conv_pkg;

    localparam int DSIZE_DEF = 256;
    localparam int KSIZE_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Rounds the byte count up to whole words; W*H+3 always fits in 16 bits for 8-bit W and H.
    function automatic logic [15:0] calc_nwords(input logic [7:0] w, input logic [7:0] h);
        logic [15:0] area;
        area = {8'd0, w} * {8'd0, h};
        return (area + 16'd3) >> 2;
    endfunction

endpackage

// File: rtl/conv_job_check.sv
// Combinational job descriptor validation.
// Ports:
//   width_i, height_i   : image dimensions
//   stride_x_i/_y_i     : strides
//   kw_i, kh_i          : kernel dimensions
//   reject_o            : high when the descriptor cannot be run on the attached conv
module conv_job_check
    import conv_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int KSIZE = KSIZE_DEF
) (
    input  logic [7:0] width_i,
    input  logic [7:0] height_i,
    input  logic [3:0] stride_x_i,
    input  logic [3:0] stride_y_i,
    input  logic [3:0] kw_i,
    input  logic [3:0] kh_i,
    output logic       reject_o
);

    localparam logic [3:0]  KMAX = 4'(KSIZE);
    localparam logic [16:0] DMAX = 17'(DSIZE);

    logic [15:0] area;

    assign area = {8'd0, width_i} * {8'd0, height_i};

    // Any single violation rejects; the area test is widened so DSIZE itself is a legal image size.
    assign reject_o = (kw_i == 4'd0) || (kh_i == 4'd0)
                   || (kw_i > KMAX)  || (kh_i > KMAX)
                   || ({4'd0, kw_i} > width_i) || ({4'd0, kh_i} > height_i)
                   || (stride_x_i == 4'd0) || (stride_y_i == 4'd0)
                   || ({1'b0, area} > DMAX);

endmodule

// File: rtl/conv_job_sequencer.sv
// Front-end controller for one conv instance: accepts a job descriptor, loads the image into
// the conv DI memory, kicks the conv, waits for done and streams the DO memory back out.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   job_*                           : descriptor handshake and fields
//   in_valid/in_ready/in_data       : image word stream (little-endian bytes)
//   out_valid/out_ready/out_data/out_last : result word stream
//   busy, err                       : job in progress, one-cycle reject pulse
//   cv_*                            : configuration, memory ports and start/done of the conv
module conv_job_sequencer
    import conv_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int KSIZE = KSIZE_DEF,
    parameter int AW    = $clog2(DSIZE) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [7:0]                job_width,
    input  logic [7:0]                job_height,
    input  logic [3:0]                job_stride_x,
    input  logic [3:0]                job_stride_y,
    input  logic [3:0]                job_kw,
    input  logic [3:0]                job_kh,
    input  logic [8*KSIZE*KSIZE-1:0]  job_kernel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err,
    output logic [7:0]                cv_data_width,
    output logic [7:0]                cv_data_height,
    output logic [7:0]                cv_di_x_stop,
    output logic [7:0]                cv_di_y_stop,
    output logic [3:0]                cv_stride_x,
    output logic [3:0]                cv_stride_y,
    output logic [3:0]                cv_kernel_width,
    output logic [3:0]                cv_kernel_height,
    output logic [8*KSIZE*KSIZE-1:0]  cv_kernel,
    output logic [AW-1:0]             cv_mi_addr,
    output logic [31:0]               cv_mi_data,
    output logic                      cv_mi_wr,
    output logic [AW-1:0]             cv_mo_addr,
    input  logic [31:0]               cv_mo_data,
    output logic                      cv_start,
    input  logic                      cv_done
);

    state_e                     state_q;
    logic [15:0]                wc_q;
    logic [15:0]                nwords_q;
    logic [7:0]                 width_q;
    logic [7:0]                 height_q;
    logic [3:0]                 stride_x_q;
    logic [3:0]                 stride_y_q;
    logic [3:0]                 kw_q;
    logic [3:0]                 kh_q;
    logic [8*KSIZE*KSIZE-1:0]   kernel_q;
    logic                       err_q;
    logic                       reject;
    logic                       lastWord;
    logic [AW-1:0]              wordAddr;

    conv_job_check #(
        .DSIZE (DSIZE),
        .KSIZE (KSIZE)
    ) u_check (
        .width_i    (job_width),
        .height_i   (job_height),
        .stride_x_i (job_stride_x),
        .stride_y_i (job_stride_y),
        .kw_i       (job_kw),
        .kh_i       (job_kh),
        .reject_o   (reject)
    );

    assign lastWord = (wc_q == nwords_q - 16'd1);
    assign wordAddr = AW'({wc_q, 2'b00});

    // Sequencer FSM: the word counter walks the image in LOAD and again in DRAIN.
    // The descriptor is only latched on acceptance so the conv config stays stable for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wc_q       <= '0;
            nwords_q   <= '0;
            width_q    <= '0;
            height_q   <= '0;
            stride_x_q <= '0;
            stride_y_q <= '0;
            kw_q       <= '0;
            kh_q       <= '0;
            kernel_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (job_valid) begin
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            width_q    <= job_width;
                            height_q   <= job_height;
                            stride_x_q <= job_stride_x;
                            stride_y_q <= job_stride_y;
                            kw_q       <= job_kw;
                            kh_q       <= job_kh;
                            kernel_q   <= job_kernel;
                            nwords_q   <= calc_nwords(job_width, job_height);
                            wc_q       <= '0;
                            state_q    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (lastWord) begin
                            wc_q    <= '0;
                            state_q <= ST_KICK;
                        end else begin
                            wc_q <= wc_q + 16'd1;
                        end
                    end
                end
                ST_KICK: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (cv_done) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (lastWord) begin
                            wc_q    <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            wc_q <= wc_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign job_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign in_ready  = (state_q == ST_LOAD);
    assign cv_start  = (state_q == ST_KICK);
    assign out_valid = (state_q == ST_DRAIN);

    // Memory ports are gated by state so they read as zero whenever their phase is not active.
    assign cv_mi_wr   = in_ready & in_valid;
    assign cv_mi_addr = in_ready ? wordAddr : '0;
    assign cv_mi_data = in_ready ? in_data : '0;
    assign cv_mo_addr = out_valid ? wordAddr : '0;
    assign out_data   = out_valid ? cv_mo_data : '0;
    assign out_last   = out_valid & lastWord;

    assign cv_data_width    = width_q;
    assign cv_data_height   = height_q;
    assign cv_di_x_stop     = width_q - {4'd0, kw_q};
    assign cv_di_y_stop     = height_q - {4'd0, kh_q};
    assign cv_stride_x      = stride_x_q;
    assign cv_stride_y      = stride_y_q;
    assign cv_kernel_width  = kw_q;
    assign cv_kernel_height = kh_q;
    assign cv_kernel        = kernel_q;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Testbench for conv_job_sequencer. A behavioural conv stand-in owns the DI/DO memories;
// expected output words are computed from the bench's own image/kernel and queued per job.
module tb_conv_job_sequencer;

    localparam int DSIZE = 256;
    localparam int KSIZE = 3;
    localparam int AW    = 9;
    localparam int KB    = 8 * KSIZE * KSIZE;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            job_valid = 1'b0;
    logic            job_ready;
    logic [7:0]      job_width = '0;
    logic [7:0]      job_height = '0;
    logic [3:0]      job_stride_x = '0;
    logic [3:0]      job_stride_y = '0;
    logic [3:0]      job_kw = '0;
    logic [3:0]      job_kh = '0;
    logic [KB-1:0]   job_kernel = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_data;
    logic            out_last;
    logic            busy;
    logic            err;
    logic [7:0]      cv_data_width, cv_data_height, cv_di_x_stop, cv_di_y_stop;
    logic [3:0]      cv_stride_x, cv_stride_y, cv_kernel_width, cv_kernel_height;
    logic [KB-1:0]   cv_kernel;
    logic [AW-1:0]   cv_mi_addr;
    logic [31:0]     cv_mi_data;
    logic            cv_mi_wr;
    logic [AW-1:0]   cv_mo_addr;
    logic [31:0]     cv_mo_data;
    logic            cv_start;
    logic            cv_done;

    int checks = 0;
    int errors = 0;

    logic [32:0] expQ[$];
    logic [7:0]  diMem [0:255];
    logic [7:0]  doMem [0:255];
    int          imgBytes [0:255];
    int          kern [0:8];
    int          tW, tH, tSx, tSy, tKw, tKh;
    int          startCount = 0;
    int          writeCount = 0;
    int          lastWrAddr = -1;
    logic        stubDone;
    int          doneTimer;
    logic        spuriousDone = 1'b0;

    conv_job_sequencer #(.DSIZE(DSIZE), .KSIZE(KSIZE), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_width(job_width), .job_height(job_height),
        .job_stride_x(job_stride_x), .job_stride_y(job_stride_y),
        .job_kw(job_kw), .job_kh(job_kh), .job_kernel(job_kernel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err),
        .cv_data_width(cv_data_width), .cv_data_height(cv_data_height),
        .cv_di_x_stop(cv_di_x_stop), .cv_di_y_stop(cv_di_y_stop),
        .cv_stride_x(cv_stride_x), .cv_stride_y(cv_stride_y),
        .cv_kernel_width(cv_kernel_width), .cv_kernel_height(cv_kernel_height),
        .cv_kernel(cv_kernel),
        .cv_mi_addr(cv_mi_addr), .cv_mi_data(cv_mi_data), .cv_mi_wr(cv_mi_wr),
        .cv_mo_addr(cv_mo_addr), .cv_mo_data(cv_mo_data),
        .cv_start(cv_start), .cv_done(cv_done)
    );

    always #5 clk = ~clk;

    assign cv_done    = stubDone | spuriousDone;
    assign cv_mo_data = {doMem[cv_mo_addr + 9'd3], doMem[cv_mo_addr + 9'd2],
                         doMem[cv_mo_addr + 9'd1], doMem[cv_mo_addr]};

    // Conv stand-in, DI side: byte-wise write of each word plus bookkeeping of writes.
    always @(posedge clk) begin
        if (rst_n && cv_mi_wr) begin
            for (int k = 0; k < 4; k++) begin
                diMem[int'(cv_mi_addr) + k] <= cv_mi_data[8*k +: 8];
            end
            writeCount <= writeCount + 1;
            lastWrAddr <= int'(cv_mi_addr);
        end
        if (rst_n && cv_start) begin
            startCount <= startCount + 1;
        end
    end

    // Conv stand-in, compute side: convolves DI into DO from the configuration ports,
    // then raises done a few cycles after start.
    task automatic stubCompute();
        int sum, w, idx;
        for (int b = 0; b < 256; b++) doMem[b] = 8'h00;
        w = int'(cv_data_width);
        if (cv_stride_x == 0 || cv_stride_y == 0) return;
        for (int y = 0; y <= int'(cv_di_y_stop); y += int'(cv_stride_y)) begin
            for (int x = 0; x <= int'(cv_di_x_stop); x += int'(cv_stride_x)) begin
                sum = 0;
                for (int j = 0; j < int'(cv_kernel_height); j++) begin
                    for (int i = 0; i < int'(cv_kernel_width); i++) begin
                        idx = (x + i) + (y + j) * w;
                        if (idx < 256)
                            sum += int'(diMem[idx]) * int'(cv_kernel[8*(j*KSIZE+i) +: 8]);
                    end
                end
                idx = x + y * w;
                if (idx < 256) doMem[idx] = (sum > 255) ? 8'hFF : 8'(sum);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doneTimer <= 0;
            stubDone  <= 1'b0;
        end else begin
            stubDone <= 1'b0;
            if (cv_start) begin
                stubCompute();
                doneTimer <= 5;
            end else if (doneTimer != 0) begin
                doneTimer <= doneTimer - 1;
                if (doneTimer == 1) stubDone <= 1'b1;
            end
        end
    end

    // Scoreboard: every completed output beat is compared against the oldest queued word.
    always begin
        logic [32:0] exp;
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL out_beat_unexpected: got data=%h last=%b, no word expected", out_data, out_last);
            end else begin
                exp = expQ.pop_front();
                if ({out_last, out_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL out_beat: got last=%b data=%h, want last=%b data=%h",
                             out_last, out_data, exp[32], exp[31:0]);
                end
            end
        end
    end

    // Reference result byte b of the output window, from the bench's own image and kernel.
    function automatic logic [7:0] expByte(int b);
        int x, y, sum;
        if (b >= tW * tH) return 8'h00;
        x = b % tW;
        y = b / tW;
        if (x > tW - tKw || y > tH - tKh || (x % tSx) != 0 || (y % tSy) != 0) return 8'h00;
        sum = 0;
        for (int j = 0; j < tKh; j++)
            for (int i = 0; i < tKw; i++)
                sum += imgBytes[(x + i) + (y + j) * tW] * kern[j * KSIZE + i];
        return (sum > 255) ? 8'hFF : 8'(sum);
    endfunction

    task automatic pushExpected();
        int n;
        logic [31:0] d;
        n = (tW * tH + 3) / 4;
        for (int w = 0; w < n; w++) begin
            d = {expByte(4*w+3), expByte(4*w+2), expByte(4*w+1), expByte(4*w)};
            expQ.push_back({(w == n - 1), d});
        end
    endtask

    // Presents one descriptor for a single cycle; returns at the negedge after the handshake edge.
    task automatic submitJob(input int w, input int h, input int sx, input int sy, input int kw, input int kh);
        tW = w; tH = h; tSx = sx; tSy = sy; tKw = kw; tKh = kh;
        @(negedge clk);
        job_width    = 8'(w);
        job_height   = 8'(h);
        job_stride_x = 4'(sx);
        job_stride_y = 4'(sy);
        job_kw       = 4'(kw);
        job_kh       = 4'(kh);
        for (int i = 0; i < KSIZE * KSIZE; i++) job_kernel[8*i +: 8] = 8'(kern[i]);
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    // Streams n image words with continuous valid; optionally raises a stray cv_done on one beat.
    task automatic loadImage(input int n, input int spurAt);
        int i, cyc;
        logic acc;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 100) begin
            in_valid = 1'b1;
            in_data  = {8'(imgBytes[4*i+3]), 8'(imgBytes[4*i+2]), 8'(imgBytes[4*i+1]), 8'(imgBytes[4*i])};
            spuriousDone = (i == spurAt);
            #1;
            acc = in_ready;
            @(negedge clk);
            cyc++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        spuriousDone = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("[TB] FAIL load_timeout: got %0d beats, want %0d", i, n);
        end
    endtask

    task automatic waitStart(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            #1;
            if (cv_start) seen = 1'b1;
            @(negedge clk);
        end
    endtask

    // Drains up to maxBeats words with out_ready held high; returns the first word seen.
    task automatic drainBeats(input int maxBeats, output int beats, output logic [31:0] first);
        int cyc;
        beats = 0;
        cyc = 0;
        first = '0;
        while (beats < maxBeats && cyc < 200) begin
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (beats == 0) first = out_data;
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic setupSmallJob();
        for (int i = 0; i < 256; i++) imgBytes[i] = (i < 16) ? i : 0;
        for (int i = 0; i < 9; i++) kern[i] = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({job_ready, busy, err, in_ready, out_valid, out_last, cv_start, cv_mi_wr} !== 8'b1000_0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, want 10000000",
                     {job_ready, busy, err, in_ready, out_valid, out_last, cv_start, cv_mi_wr});
        end
        checks++;
        if ({out_data, cv_data_width, cv_di_x_stop, cv_mo_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: out_data=%h width=%h xstop=%h mo_addr=%h",
                     out_data, cv_data_width, cv_di_x_stop, cv_mo_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: job_ready=%b busy=%b, want 1 0", job_ready, busy);
        end
    endtask

    task automatic test_basic_job();
        bit seen;
        int beats, starts0;
        logic [31:0] first;
        $display("[TB] basic 4x4 job");
        setupSmallJob();
        starts0 = startCount;
        submitJob(4, 4, 1, 1, 3, 3);
        pushExpected();
        #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || job_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept_state: busy=%b in_ready=%b job_ready=%b, want 1 1 0", busy, in_ready, job_ready);
        end
        loadImage(4, -1);
        waitStart(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL start_timeout: cv_start not seen");
        end
        checks++;
        if (cv_di_x_stop !== 8'd1 || cv_di_y_stop !== 8'd1 || cv_data_width !== 8'd4) begin
            errors++;
            $display("[TB] FAIL config: xstop=%0d ystop=%0d width=%0d, want 1 1 4", cv_di_x_stop, cv_di_y_stop, cv_data_width);
        end
        drainBeats(4, beats, first);
        checks++;
        if (beats != 4) begin
            errors++;
            $display("[TB] FAIL drain_beats: got %0d, want 4", beats);
        end
        checks++;
        if (first[15:0] !== 16'h362D) begin
            errors++;
            $display("[TB] FAIL first_bytes: got %h, want 362d (54,45)", first[15:0]);
        end
        checks++;
        if (startCount - starts0 != 1) begin
            errors++;
            $display("[TB] FAIL start_count: got %0d, want 1", startCount - starts0);
        end
    endtask

    task automatic test_stall();
        bit seen, stalled;
        int beats, extra, cyc;
        logic [31:0] held;
        bit pat [0:3];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        $display("[TB] stalled drain");
        setupSmallJob();
        submitJob(4, 4, 1, 1, 3, 3);
        pushExpected();
        loadImage(4, -1);
        waitStart(seen);
        beats = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (beats < 4 && cyc < 200) begin
            out_ready = pat[cyc % 4];
            #1;
            if (out_valid) begin
                if (stalled) begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got %h, want %h", out_data, held);
                    end
                end
                if (!out_ready) begin
                    stalled = 1'b1;
                    held = out_data;
                end else begin
                    stalled = 1'b0;
                    beats++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (beats != 4 || busy !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_end: beats=%0d busy=%b job_ready=%b, want 4 0 1", beats, busy, job_ready);
        end
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid) extra++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL extra_beats: got %0d, want 0", extra);
        end
    endtask

    task automatic test_reject();
        int w0, s0;
        int rw [0:2];
        int rh [0:2];
        int rsx [0:2];
        int rkw [0:2];
        rw[0] = 4;  rh[0] = 4;  rsx[0] = 1; rkw[0] = 4;
        rw[1] = 16; rh[1] = 17; rsx[1] = 1; rkw[1] = 3;
        rw[2] = 4;  rh[2] = 4;  rsx[2] = 0; rkw[2] = 3;
        $display("[TB] rejected descriptors");
        w0 = writeCount;
        s0 = startCount;
        for (int r = 0; r < 3; r++) begin
            submitJob(rw[r], rh[r], rsx[r], 1, rkw[r], 3);
            #1;
            checks++;
            if (err !== 1'b1 || job_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reject_%0d: err=%b job_ready=%b busy=%b, want 1 1 0", r, err, job_ready, busy);
            end
            @(negedge clk);
            #1;
            checks++;
            if (err !== 1'b0 || job_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reject_pulse_%0d: err=%b job_ready=%b, want 0 1", r, err, job_ready);
            end
        end
        checks++;
        if (writeCount != w0 || startCount != s0) begin
            errors++;
            $display("[TB] FAIL reject_side_effects: writes=%0d starts=%0d, want 0 0", writeCount - w0, startCount - s0);
        end
    endtask

    task automatic test_odd_size();
        bit seen;
        int beats;
        logic [31:0] first;
        $display("[TB] 5x3 job");
        for (int i = 0; i < 256; i++) imgBytes[i] = (i < 15) ? i : 8'hA5;
        for (int i = 0; i < 9; i++) kern[i] = i + 1;
        submitJob(5, 3, 1, 1, 3, 3);
        pushExpected();
        loadImage(4, -1);
        checks++;
        if (lastWrAddr != 12) begin
            errors++;
            $display("[TB] FAIL odd_last_addr: got %0d, want 12", lastWrAddr);
        end
        waitStart(seen);
        drainBeats(4, beats, first);
        #1;
        checks++;
        if (beats != 4 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL odd_drain: beats=%0d busy=%b, want 4 0", beats, busy);
        end
    endtask

    task automatic test_spurious_done();
        bit seen;
        int beats;
        logic [31:0] first;
        $display("[TB] stray done during load");
        setupSmallJob();
        submitJob(4, 4, 1, 1, 3, 3);
        pushExpected();
        loadImage(4, 1);
        waitStart(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL spur_start: cv_start not seen");
        end
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL spur_run_wait: out_valid=%b busy=%b, want 0 1", out_valid, busy);
        end
        @(negedge clk);
        drainBeats(4, beats, first);
        checks++;
        if (beats != 4) begin
            errors++;
            $display("[TB] FAIL spur_drain: beats=%0d, want 4", beats);
        end
    endtask

    task automatic test_reset_mid_drain();
        bit seen;
        int beats;
        logic [31:0] first;
        $display("[TB] reset during drain");
        setupSmallJob();
        submitJob(4, 4, 1, 1, 3, 3);
        pushExpected();
        loadImage(4, -1);
        waitStart(seen);
        drainBeats(2, beats, first);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0
            || cv_data_width !== 8'd0 || cv_mo_addr !== '0) begin
            errors++;
            $display("[TB] FAIL midreset: out_valid=%b job_ready=%b busy=%b width=%0d mo_addr=%0d",
                     out_valid, job_ready, busy, cv_data_width, cv_mo_addr);
        end
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        submitJob(4, 4, 1, 1, 3, 3);
        pushExpected();
        loadImage(4, -1);
        waitStart(seen);
        drainBeats(4, beats, first);
        #1;
        checks++;
        if (beats != 4 || first[7:0] !== 8'd45 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_job: beats=%0d byte0=%0d busy=%b, want 4 45 0", beats, first[7:0], busy);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic_job();
        test_stall();
        test_reject();
        test_odd_size();
        test_spurious_done();
        test_reset_mid_drain();
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_words: %0d expected words never produced", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
